global_trigger_coordinator: RTL and testbench

Downstream of the eight per-link thresholders. It collects each thresholder's per-sample `set_global_trigger` pulse and packet `time_stamp`, and applies a multi-channel coincidence window. On a qualified event it issues one trigger record (timestamp, channel mask, hit count) to the address generator over a valid/ready handshake. It then drives `Global_trigger_flag` back to the thresholders for the emit and hold-off period.

---
 rtl/trigger_pkg.sv | 20 ++
 rtl/global_trigger_coordinator_if.sv | 22 ++
 rtl/coinc_popcount.sv | 16 +
 rtl/global_trigger_coordinator.sv | 144 ++++++++++++++
 tb/tb_global_trigger_coordinator.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/trigger_pkg.sv
// Shared types and constants for the global trigger coordinator.
// State encoding, default channel/timestamp sizing and reset values.
package trigger_pkg;

    localparam int DEF_NUM_CH   = 8;
    localparam int DEF_TS_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_HOLDOFF = 2'd3
    } trig_state_t;

    localparam logic        RST_VALID  = 1'b0;
    localparam logic        RST_FLAG   = 1'b0;
    localparam logic [15:0] RST_REJECT = 16'h0000;
    localparam logic [15:0] REJECT_MAX = 16'hFFFF;

endpackage

// File: rtl/global_trigger_coordinator_if.sv
// Trigger record handshake towards the address generator.
// master drives the record and valid, slave returns ready.
interface global_trigger_coordinator_if #(
    parameter int NUM_CH   = trigger_pkg::DEF_NUM_CH,
    parameter int TS_WIDTH = trigger_pkg::DEF_TS_WIDTH
);
    logic                        trig_valid;
    logic                        trig_ready;
    logic [TS_WIDTH-1:0]         trig_time_stamp;
    logic [NUM_CH-1:0]           trig_ch_mask;
    logic [$clog2(NUM_CH+1)-1:0] trig_ch_count;

    modport master (
        output trig_valid, trig_time_stamp, trig_ch_mask, trig_ch_count,
        input  trig_ready
    );

    modport slave (
        input  trig_valid, trig_time_stamp, trig_ch_mask, trig_ch_count,
        output trig_ready
    );
endinterface

// File: rtl/coinc_popcount.sv
// Combinational population count of the channel hit vector.
// Zero latency, no flow control.
module coinc_popcount #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0] i_vec,
    output logic [CNT_W-1:0]  o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_count = o_count + CNT_W'(i_vec[i]);
        end
    end
endmodule

// File: rtl/global_trigger_coordinator.sv
// Multi-channel coincidence window: anchors on the first hit, collects channels within TS_TOL,
// emits one record when enough channels agree (held until ready), then holds off re-triggering.
module global_trigger_coordinator
    import trigger_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int TS_WIDTH    = DEF_TS_WIDTH,
    parameter int WINDOW_CYC  = 128,
    parameter int TS_TOL      = 1,
    parameter int MIN_COINC   = 2,
    parameter int HOLDOFF_CYC = 64
) (
    input  logic                         rx_std_clkout,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_trigger,
    input  logic [NUM_CH*TS_WIDTH-1:0]   ch_time_stamp,
    global_trigger_coordinator_if.master trig,
    output logic                         Global_trigger_flag,
    output logic [15:0]                  reject_count
);
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int WIN_W = $clog2(WINDOW_CYC + 1);
    localparam int HO_W  = $clog2(HOLDOFF_CYC + 1);

    trig_state_t         r_state;
    logic [NUM_CH-1:0]   r_hit_mask;
    logic [TS_WIDTH-1:0] r_anchor_ts;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [HO_W-1:0]     r_ho_cnt;
    logic                r_valid;
    logic [TS_WIDTH-1:0] r_ts;
    logic [NUM_CH-1:0]   r_mask;
    logic [CNT_W-1:0]    r_count;
    logic                r_flag;
    logic [15:0]         r_reject;

    logic [TS_WIDTH-1:0] w_first_ts;
    logic [TS_WIDTH-1:0] w_ref_ts;
    logic [NUM_CH-1:0]   w_accept;
    logic [NUM_CH-1:0]   w_next_mask;
    logic [CNT_W-1:0]    w_pop;

    // Lowest-index asserting channel wins the anchor, so scan from the top down.
    always_comb begin
        w_first_ts = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_trigger[i]) begin
                w_first_ts = ch_time_stamp[i*TS_WIDTH +: TS_WIDTH];
            end
        end
    end

    assign w_ref_ts = (r_state == ST_IDLE) ? w_first_ts : r_anchor_ts;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_accept
        logic [TS_WIDTH-1:0] w_ts;
        logic [TS_WIDTH-1:0] w_fwd;
        logic [TS_WIDTH-1:0] w_bwd;
        assign w_ts  = ch_time_stamp[g*TS_WIDTH +: TS_WIDTH];
        assign w_fwd = w_ts - w_ref_ts;
        assign w_bwd = w_ref_ts - w_ts;
        assign w_accept[g] = ch_trigger[g] && !r_hit_mask[g] &&
                             ((w_fwd <= TS_WIDTH'(TS_TOL)) || (w_bwd <= TS_WIDTH'(TS_TOL)));
    end

    assign w_next_mask = r_hit_mask | w_accept;

    coinc_popcount #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_popcount (
        .i_vec   (w_next_mask),
        .o_count (w_pop)
    );

    always_ff @(posedge rx_std_clkout) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hit_mask  <= '0;
            r_anchor_ts <= '0;
            r_win_cnt   <= '0;
            r_ho_cnt    <= '0;
            r_valid     <= RST_VALID;
            r_ts        <= '0;
            r_mask      <= '0;
            r_count     <= '0;
            r_flag      <= RST_FLAG;
            r_reject    <= RST_REJECT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|ch_trigger) begin
                        r_anchor_ts <= w_first_ts;
                        r_hit_mask  <= w_accept;
                        r_win_cnt   <= WIN_W'(1);
                        r_state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    r_hit_mask <= w_next_mask;
                    if (r_win_cnt == WIN_W'(WINDOW_CYC - 1)) begin
                        if (w_pop >= CNT_W'(MIN_COINC)) begin
                            r_ts    <= r_anchor_ts;
                            r_mask  <= w_next_mask;
                            r_count <= w_pop;
                            r_valid <= 1'b1;
                            r_flag  <= 1'b1;
                            r_state <= ST_EMIT;
                        end else begin
                            if (r_reject != REJECT_MAX) begin
                                r_reject <= r_reject + 16'd1;
                            end
                            r_hit_mask <= '0;
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (trig.trig_ready) begin
                        r_valid    <= 1'b0;
                        r_hit_mask <= '0;
                        r_ho_cnt   <= '0;
                        r_state    <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_ho_cnt == HO_W'(HOLDOFF_CYC - 1)) begin
                        r_flag  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ho_cnt <= r_ho_cnt + HO_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign trig.trig_valid      = r_valid;
    assign trig.trig_time_stamp = r_ts;
    assign trig.trig_ch_mask    = r_mask;
    assign trig.trig_ch_count   = r_count;
    assign Global_trigger_flag  = r_flag;
    assign reject_count         = r_reject;
endmodule

// File: tb/tb_global_trigger_coordinator.sv
// Randomized and directed coincidence windows checked against a set-based window model.
module tb_global_trigger_coordinator;
    localparam int NCH  = 8;
    localparam int TSW  = 16;
    localparam int WIN  = 128;
    localparam int HOLD = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   ch_trigger;
    logic [NCH*TSW-1:0] ch_time_stamp;
    logic             flag;
    logic [15:0]      reject_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_reject = 0;

    logic [NCH-1:0] s_trig [WIN];
    logic [TSW-1:0] s_ts   [WIN][NCH];

    always #5 clk = ~clk;

    global_trigger_coordinator_if trig_if ();

    global_trigger_coordinator #(
        .NUM_CH(NCH), .TS_WIDTH(TSW), .WINDOW_CYC(WIN),
        .TS_TOL(1), .MIN_COINC(2), .HOLDOFF_CYC(HOLD)
    ) dut (
        .rx_std_clkout       (clk),
        .rst                 (rst),
        .ch_trigger          (ch_trigger),
        .ch_time_stamp       (ch_time_stamp),
        .trig                (trig_if),
        .Global_trigger_flag (flag),
        .reject_count        (reject_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        ch_trigger    = NCH'($urandom);
        ch_time_stamp = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic clear_stim();
        for (int k = 0; k < WIN; k++) begin
            s_trig[k] = '0;
            for (int c = 0; c < NCH; c++) s_ts[k][c] = TSW'($urandom);
        end
    endtask

    task automatic set_hit(input int k, input int c, input logic [TSW-1:0] ts);
        s_trig[k][c] = 1'b1;
        s_ts[k][c]   = ts;
    endtask

    function automatic bit near(input logic [TSW-1:0] x, input logic [TSW-1:0] a);
        logic [TSW-1:0] d1, d2;
        d1 = x - a;
        d2 = a - x;
        return (d1 <= 1) || (d2 <= 1);
    endfunction

    // A channel contributes if any of its hits in the window lies within tolerance of the anchor.
    task automatic model_window(output logic [NCH-1:0] m, output logic [TSW-1:0] a);
        a = '0;
        for (int c = NCH - 1; c >= 0; c--) if (s_trig[0][c]) a = s_ts[0][c];
        m = '0;
        for (int k = 0; k < WIN; k++)
            for (int c = 0; c < NCH; c++)
                if (s_trig[k][c] && near(s_ts[k][c], a)) m[c] = 1'b1;
    endtask

    task automatic build_random();
        logic [TSW-1:0] base;
        int dens;
        base = ($urandom_range(0, 3) == 0) ? 16'hFFFF : TSW'($urandom);
        dens = $urandom_range(1, 12);
        clear_stim();
        set_hit(0, $urandom_range(0, NCH-1), base + TSW'($urandom_range(0, 4)) - 16'd2);
        for (int h = 0; h < dens; h++)
            set_hit($urandom_range(0, WIN-1), $urandom_range(0, NCH-1),
                    base + TSW'($urandom_range(0, 6)) - 16'd3);
    endtask

    task automatic run_window(input int ready_delay, input bit rst_in_emit);
        logic [NCH-1:0] exp_mask;
        logic [TSW-1:0] exp_ts;
        int exp_cnt, n_ho;
        bit exp_q, early, stable, retrig;
        model_window(exp_mask, exp_ts);
        exp_cnt = $countones(exp_mask);
        exp_q   = (exp_cnt >= 2);
        early   = 0;
        for (int k = 0; k < WIN; k++) begin
            ch_trigger = s_trig[k];
            for (int c = 0; c < NCH; c++) ch_time_stamp[c*TSW +: TSW] = s_ts[k][c];
            tick();
            if (k < WIN - 1 && (trig_if.trig_valid || flag)) early = 1;
        end
        ch_trigger = '0;
        chk("no_early_output", 32'(early), 32'd0);
        chk("trig_valid", 32'(trig_if.trig_valid), 32'(exp_q));
        chk("flag_at_close", 32'(flag), 32'(exp_q));
        if (!exp_q) begin
            if (exp_reject < 16'hFFFF) exp_reject++;
            chk("reject_count", 32'(reject_count), 32'(exp_reject));
            return;
        end
        chk("trig_ts", 32'(trig_if.trig_time_stamp), 32'(exp_ts));
        chk("trig_mask", 32'(trig_if.trig_ch_mask), 32'(exp_mask));
        chk("trig_count", 32'(trig_if.trig_ch_count), 32'(exp_cnt));
        if (rst_in_emit) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_reject = 0;
            chk("rst_valid", 32'(trig_if.trig_valid), 32'd0);
            chk("rst_flag", 32'(flag), 32'd0);
            chk("rst_reject", 32'(reject_count), 32'd0);
            return;
        end
        stable = 1;
        for (int d = 0; d < ready_delay; d++) begin
            rand_inputs();
            tick();
            if (trig_if.trig_valid !== 1'b1 || trig_if.trig_time_stamp !== exp_ts ||
                trig_if.trig_ch_mask !== exp_mask || trig_if.trig_ch_count !== 4'(exp_cnt))
                stable = 0;
        end
        chk("record_stable", 32'(stable), 32'd1);
        trig_if.trig_ready = 1'b1;
        rand_inputs();
        tick();
        trig_if.trig_ready = 1'b0;
        chk("valid_drop", 32'(trig_if.trig_valid), 32'd0);
        n_ho   = 0;
        retrig = 0;
        for (int i = 0; i < 3 * HOLD && flag; i++) begin
            n_ho++;
            rand_inputs();
            tick();
            if (trig_if.trig_valid) retrig = 1;
        end
        ch_trigger = '0;
        chk("holdoff_len", 32'(n_ho), 32'(HOLD));
        chk("no_retrigger", 32'(retrig), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ch_trigger = '0;
        ch_time_stamp = '0;
        trig_if.trig_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(trig_if.trig_valid), 32'd0);
        chk("reset_flag", 32'(flag), 32'd0);
        chk("reset_reject", 32'(reject_count), 32'd0);
        chk("reset_mask", 32'(trig_if.trig_ch_mask), 32'd0);
        chk("reset_count", 32'(trig_if.trig_ch_count), 32'd0);
        chk("reset_ts", 32'(trig_if.trig_time_stamp), 32'd0);
        rst = 1'b0;
        tick();

        clear_stim();
        set_hit(0, 0, 16'h1234);
        set_hit(5, 3, 16'h1234);
        run_window(10, 0);

        clear_stim();
        for (int k = 0; k < 125; k++) set_hit(k, 2, 16'h0100);
        run_window(0, 0);

        clear_stim();
        set_hit(0, 1, 16'hFFFF);
        set_hit(3, 6, 16'h0000);
        set_hit(7, 4, 16'h0005);
        run_window(2, 0);

        clear_stim();
        set_hit(0, 0, 16'h0777);
        set_hit(WIN-1, 5, 16'h0777);
        run_window(0, 0);

        for (int w = 0; w < 10; w++) begin
            build_random();
            run_window($urandom_range(0, 5), 0);
        end

        clear_stim();
        set_hit(0, 0, 16'h4000);
        set_hit(1, 1, 16'h4001);
        run_window(0, 1);

        build_random();
        run_window(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
